// File: rtl/lsu_pkg.sv
// Shared constants for the MEM-stage load/store unit: funct3 codes, FSM encoding, lane masks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BE_B    = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

endpackage

// File: rtl/load_align_ext.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    value = {{16{half_sel[15]}}, half_sel};
            F3_BU:   value = {24'h000000, byte_sel};
            F3_HU:   value = {16'h0000, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory handshake, lane steering, fault detection.
// Optional ack timeout enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memValid,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [2:0]        memFunct3,
    input  logic [31:0]       memAluRes,
    input  logic [31:0]       memStoreData,
    output logic              dmemReq,
    output logic              dmemWe,
    output logic [ADDR_W-1:0] dmemAddr,
    output logic [31:0]       dmemWdata,
    output logic [3:0]        dmemBe,
    input  logic [31:0]       dmemRdata,
    input  logic              dmemAck,
    output logic [31:0]       memMemValue,
    output logic              memStall,
    output logic              memFault
);

    lsu_state_e  state_q, state_d;
    logic        op, is_store, illegal, misaligned;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        start, fault_d, timeout_hit;
    logic [1:0]  lo_q;
    logic [2:0]  f3_q;
    logic        load_q;
    logic [31:0] ext_value;

    assign op       = memValid & (memRead | memWrite);
    // Read and write both set is treated as a load.
    assign is_store = memWrite & ~memRead;

    always_comb begin
        case (memFunct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_store;
            default:          illegal = 1'b1;
        endcase
        misaligned = 1'b0;
        if (memFunct3[1:0] == 2'b01) begin
            misaligned = memAluRes[0];
        end else if (memFunct3[1:0] == 2'b10) begin
            misaligned = |memAluRes[1:0];
        end
        case (memFunct3[1:0])
            2'b00: begin
                be_d    = BE_B << memAluRes[1:0];
                wdata_d = {4{memStoreData[7:0]}};
            end
            2'b01: begin
                be_d    = memAluRes[1] ? BE_H_HI : BE_H_LO;
                wdata_d = {2{memStoreData[15:0]}};
            end
            default: begin
                be_d    = BE_W;
                wdata_d = memStoreData;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= (state_q == S_BUSY) ? cnt_q + CNT_W'(1) : '0;
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        memStall = 1'b0;
        fault_d  = 1'b0;
        start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op) begin
                    if (illegal || misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        start    = 1'b1;
                        memStall = 1'b1;
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                memStall = 1'b1;
                if (dmemAck) begin
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    load_align_ext u_align (
        .rdata  (dmemRdata),
        .addr   (lo_q),
        .funct3 (f3_q),
        .value  (ext_value)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            dmemReq     <= 1'b0;
            dmemWe      <= 1'b0;
            dmemAddr    <= '0;
            dmemBe      <= 4'b0000;
            dmemWdata   <= 32'h0;
            memMemValue <= 32'h0;
            memFault    <= 1'b0;
            lo_q        <= 2'b00;
            f3_q        <= 3'b000;
            load_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            memFault <= fault_d;
            if (start) begin
                dmemReq   <= 1'b1;
                dmemWe    <= is_store;
                dmemAddr  <= {memAluRes[ADDR_W-1:2], 2'b00};
                dmemBe    <= be_d;
                dmemWdata <= wdata_d;
                lo_q      <= memAluRes[1:0];
                f3_q      <= memFunct3;
                load_q    <= ~is_store;
            end
            if (state_q == S_BUSY && (dmemAck || timeout_hit)) begin
                dmemReq <= 1'b0;
                dmemWe  <= 1'b0;
            end
            if (fault_d) begin
                memMemValue <= 32'h0;
            end else if (state_q == S_BUSY && dmemAck && load_q) begin
                memMemValue <= ext_value;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ops queue expected requests/results, monitor checks.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memValid, memRead, memWrite;
    logic [2:0]  memFunct3;
    logic [31:0] memAluRes, memStoreData;
    logic        dmemReq, dmemWe;
    logic [31:0] dmemAddr, dmemWdata;
    logic [3:0]  dmemBe;
    logic [31:0] dmemRdata;
    logic        dmemAck;
    logic [31:0] memMemValue;
    logic        memStall, memFault;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          chk_be;
        bit          chk_wd;
    } req_t;

    typedef struct {
        logic [31:0] val;
        logic        fault;
    } res_t;

    req_t req_exp[$];
    res_t res_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_stage_lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memValid     (memValid),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memFunct3    (memFunct3),
        .memAluRes    (memAluRes),
        .memStoreData (memStoreData),
        .dmemReq      (dmemReq),
        .dmemWe       (dmemWe),
        .dmemAddr     (dmemAddr),
        .dmemWdata    (dmemWdata),
        .dmemBe       (dmemBe),
        .dmemRdata    (dmemRdata),
        .dmemAck      (dmemAck),
        .memMemValue  (memMemValue),
        .memStall     (memStall),
        .memFault     (memFault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks each new bus request and each completed/faulted op against the queues.
    bit req_prev = 1'b0;
    bit ack_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            req_prev = 1'b0;
            ack_prev = 1'b0;
        end else begin
            if (dmemReq && !req_prev) begin
                if (req_exp.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = req_exp.pop_front();
                    check("req_we", {31'b0, dmemWe}, {31'b0, r.we});
                    check("req_addr", dmemAddr, r.addr);
                    if (r.chk_be) check("req_be", {28'b0, dmemBe}, {28'b0, r.be});
                    if (r.chk_wd) check("req_wdata", dmemWdata, r.wdata);
                end
            end
            if (memFault || ack_prev) begin
                if (res_exp.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    res_t s;
                    s = res_exp.pop_front();
                    check("res_value", memMemValue, s.val);
                    check("res_fault", {31'b0, memFault}, {31'b0, s.fault});
                end
            end
            req_prev = dmemReq;
            ack_prev = dmemReq && dmemAck;
        end
    end

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, input bit cb, input bit cw);
        req_t r;
        r.we = we; r.addr = {addr[31:2], 2'b00}; r.be = be; r.wdata = wd;
        r.chk_be = cb; r.chk_wd = cw;
        req_exp.push_back(r);
    endtask

    task automatic push_res(input logic [31:0] val, input logic fault);
        res_t s;
        s.val = val; s.fault = fault;
        res_exp.push_back(s);
    endtask

    task automatic set_in(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd);
        memValid = v; memRead = rd; memWrite = wr; memFunct3 = f3;
        memAluRes = addr; memStoreData = sd;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic mem_op(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                          input int delay, input logic [31:0] exp_val, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input bit cb, input bit cw);
        int stalls = 0;
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        set_in(1'b1, rd, wr, f3, addr, sd);
        push_req(wr & ~rd, addr, exp_be, exp_wd, cb, cw);
        push_res(exp_val, 1'b0);
        @(negedge clk);
        if (memStall) stalls++;
        @(posedge clk); #1;
        // Inputs change in BUSY and must be ignored.
        set_in(1'b0, 1'b0, 1'b1, 3'b111, 32'hFFFF_FFFF, 32'h0);
        for (int k = 1; k <= delay; k++) begin
            if (k == delay) begin
                dmemAck = 1'b1;
                dmemRdata = rdata;
            end
            @(negedge clk);
            if (memStall) stalls++;
            check({name, "_addr_stable"}, dmemAddr, waddr);
            @(posedge clk); #1;
            dmemAck = 1'b0;
            dmemRdata = 32'h0BAD_F00D;
        end
        @(negedge clk);
        if (memStall) stalls++;
        check({name, "_stall_cycles"}, stalls, delay + 1);
        @(posedge clk); #1;
    endtask

    task automatic fault_op(input string name, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
        set_in(1'b1, rd, wr, f3, addr, 32'h1234_5678);
        push_res(32'h0, 1'b1);
        @(negedge clk);
        check({name, "_stall"}, {31'b0, memStall}, 32'd0);
        check({name, "_noreq"}, {31'b0, dmemReq}, 32'd0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check({name, "_noreq2"}, {31'b0, dmemReq}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        dmemAck = 1'b0;
        dmemRdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, dmemReq}, 32'd0);
        check("rst_we", {31'b0, dmemWe}, 32'd0);
        check("rst_be", {28'b0, dmemBe}, 32'd0);
        check("rst_addr", dmemAddr, 32'd0);
        check("rst_wdata", dmemWdata, 32'd0);
        check("rst_value", memMemValue, 32'd0);
        check("rst_fault", {31'b0, memFault}, 32'd0);
        check("rst_stall", {31'b0, memStall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;

        mem_op("lw", 1, 0, 3'b010, 32'h100, 32'h1122_3344, 32'hDEAD_BEEF, 1,
               32'hDEAD_BEEF, 4'b1111, 32'h0, 1, 0);
        mem_op("lb", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 1,
               32'hFFFF_FF80, 4'b0, 32'h0, 0, 0);
        mem_op("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 1,
               32'h0000_0080, 4'b0, 32'h0, 0, 0);
        mem_op("sh", 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h5555_5555, 1,
               32'h0000_0080, 4'b1100, 32'hABCD_ABCD, 1, 1);
        mem_op("sb", 0, 1, 3'b000, 32'h001, 32'h0000_005A, 32'h5555_5555, 2,
               32'h0000_0080, 4'b0010, 32'h5A5A_5A5A, 1, 1);
        mem_op("sw", 0, 1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h5555_5555, 1,
               32'h0000_0080, 4'b1111, 32'hCAFE_F00D, 1, 1);
        mem_op("lh", 1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 1,
               32'hFFFF_8001, 4'b0, 32'h0, 0, 0);
        mem_op("lhu", 1, 0, 3'b101, 32'h100, 32'h0, 32'h8001_F00F, 1,
               32'h0000_F00F, 4'b0, 32'h0, 0, 0);
        mem_op("lw_slow", 1, 0, 3'b010, 32'h104, 32'h0, 32'h1234_5678, 5,
               32'h1234_5678, 4'b1111, 32'h0, 1, 0);
        mem_op("rw_load", 1, 1, 3'b010, 32'h020, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 1,
               32'h0F0F_0F0F, 4'b1111, 32'h0, 1, 0);

        fault_op("lw_mis", 1, 0, 3'b010, 32'h101);
        fault_op("lh_mis", 1, 0, 3'b001, 32'h001);
        fault_op("sbu_ill", 0, 1, 3'b100, 32'h000);
        fault_op("f3_ill", 1, 0, 3'b011, 32'h000);

        mem_op("sb_hi", 0, 1, 3'b000, 32'h003, 32'h1234_5677, 32'h0, 2,
               32'h0000_0000, 4'b1000, 32'h7777_7777, 1, 1);

        // Non-memory instruction: no stall, no request, value held.
        set_in(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("nonmem_stall", {31'b0, memStall}, 32'd0);
            check("nonmem_noreq", {31'b0, dmemReq}, 32'd0);
            @(posedge clk); #1;
        end
        set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("nonmem_value", memMemValue, 32'h0);
        @(posedge clk); #1;

        // Load a known value, then reset mid-BUSY and ack late.
        mem_op("lw_pre", 1, 0, 3'b010, 32'h300, 32'h0, 32'h7654_3210, 1,
               32'h7654_3210, 4'b1111, 32'h0, 1, 0);
        set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
        push_req(1'b0, 32'h304, 4'b1111, 32'h0, 1, 0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        check("busy_req", {31'b0, dmemReq}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_req", {31'b0, dmemReq}, 32'd0);
        check("midrst_stall", {31'b0, memStall}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        dmemAck = 1'b1;
        dmemRdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("lateack_req", {31'b0, dmemReq}, 32'd0);
        @(posedge clk); #1;
        dmemAck = 1'b0;
        @(negedge clk);
        check("lateack_value", memMemValue, 32'h0);
        check("lateack_fault", {31'b0, memFault}, 32'd0);
        check("lateack_stall", {31'b0, memStall}, 32'd0);
        @(posedge clk); #1;

`ifdef LSU_TIMEOUT_EN
        begin
            int  stalls = 0;
            bit  seen = 1'b0;
            set_in(1'b1, 1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
            push_req(1'b0, 32'h400, 4'b1111, 32'h0, 1, 0);
            push_res(32'h0, 1'b1);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (memFault) begin
                    seen = 1'b1;
                    break;
                end
                if (memStall) stalls++;
                @(posedge clk); #1;
                set_in(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
            end
            check("timeout_seen", {31'b0, seen}, 32'd1);
            check("timeout_stalls", stalls, 32'd17);
            @(posedge clk); #1;
            @(negedge clk);
            check("timeout_idle_stall", {31'b0, memStall}, 32'd0);
            check("timeout_idle_req", {31'b0, dmemReq}, 32'd0);
            @(posedge clk); #1;
        end
`endif

        repeat (2) @(posedge clk);
        check("req_queue_empty", req_exp.size(), 32'd0);
        check("res_queue_empty", res_exp.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit of the MEM stage, directly upstream of the MEM/WB pipeline register. It takes the EX/MEM address, store data and memory control, and runs a req/ack handshake to data memory. It produces the aligned, extended load value (memMemValue) and stalls the pipeline until the access completes. It also generates byte enables and detects misaligned or illegal accesses.

Parameters:
ADDR_W, 32, data-memory address width (low ADDR_W bits of memAluRes driven out)
TIMEOUT_CYCLES, 16, ack wait limit in cycles (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; single clock domain, reset is asynchronous and active-high (asserted when 1)
memValid  input  1  instruction in MEM stage is valid
memRead  input  1  load
memWrite  input  1  store
memFunct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
memAluRes  input  32  effective address
memStoreData  input  32  rs2 value for stores
dmemReq  output  1  bus request (registered)
dmemWe  output  1  write strobe (registered)
dmemAddr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dmemWdata  output  32  lane-replicated store data
dmemBe  output  4  byte enables
dmemRdata  input  32  read data, valid with dmemAck
dmemAck  input  1  one-cycle completion pulse
memMemValue  output  32  extended load result (registered) to MEM/WB
memStall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM; hold MEM/WB
memFault  output  1  one-cycle pulse: misaligned access, illegal funct3, or timeout

Behaviour:
- Reset (async, rst_n=1): state=IDLE; dmemReq, dmemWe, dmemBe, dmemAddr, dmemWdata, memMemValue, memFault all 0. memStall=0.
- FSM states: IDLE, BUSY, DONE.
- Op present: memValid & (memRead | memWrite). Read and write both set: treated as a load.
- IDLE, op present, legal and aligned:
  - Register dmemReq=1, dmemWe=memWrite, dmemAddr, dmemBe, dmemWdata; go to BUSY.
  - memStall=1 (combinational) in this cycle.
- IDLE, op present, illegal or misaligned:
  - Misaligned: H/HU with addr[0]!=0; W with addr[1:0]!=0. Illegal: funct3 outside the listed set; stores with funct3 other than 000/001/010.
  - No bus request. memFault=1 for one cycle; memMemValue<=0; memStall=0; stay in IDLE.
- BUSY:
  - Request signals held stable; memStall=1.
  - On dmemAck: dmemReq<=0, dmemWe<=0. For loads, memMemValue<=extend(dmemRdata); for stores, memMemValue is unchanged. Go to DONE.
- DONE: memStall=0 for exactly one cycle so the pipeline advances (MEM/WB captures memMemValue); go to IDLE.
- Minimum latency per memory op: 3 cycles (IDLE, BUSY with ack on its first cycle, DONE). Each additional ack wait cycle adds one.
- Store lanes:
  - SB: dmemBe=4'b0001<<addr[1:0]; dmemWdata={4{data[7:0]}}.
  - SH: dmemBe=addr[1]?4'b1100:4'b0011; dmemWdata={2{data[15:0]}}.
  - SW: dmemBe=4'b1111; dmemWdata=data.
- Load extract: select byte or halfword by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Address and funct3 are latched at request. Input changes while in BUSY are ignored; memValid dropping in BUSY does not abort the access.
- dmemAck in IDLE or DONE is ignored.
- Non-memory instruction (memValid=1, no read/write): memStall=0, no request, memMemValue unchanged.
- Reset mid-BUSY: immediate return to IDLE with dmemReq=0; a late ack after reset is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter runs in BUSY. If TIMEOUT_CYCLES cycles elapse without ack: dmemReq<=0, memFault pulses for 1 cycle, memMemValue<=0, go to DONE.
- Undefined: no counter; BUSY waits for ack indefinitely.

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), 2-bit state encoding (S_IDLE, S_BUSY, S_DONE), lane-mask constants.
- Sub-module load_align_ext: combinational; inputs rdata, addr[1:0], funct3; output 32-bit extended value.

Test Plan:
- LW at 0x100, ack on first BUSY cycle with dmemRdata=0xDEADBEEF -> dmemBe=1111, memStall high 2 cycles, memMemValue=0xDEADBEEF in DONE.
- LB at 0x103, rdata=0x80FF1234 -> memMemValue=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x202, data=0x0000ABCD -> dmemBe=1100, dmemWdata=0xABCDABCD, dmemWe=1; memMemValue unchanged.
- LW at 0x101 -> no dmemReq, memFault one-cycle pulse, memStall=0.
- Ack delayed 5 cycles -> memStall high 6 cycles, dmemAddr stable throughout. Assert reset in BUSY -> dmemReq=0 immediately; ack after release ignored.
- With LSU_TIMEOUT_EN and no ack -> memFault after 16 BUSY cycles, memMemValue=0, FSM returns to IDLE.
